mem_refill_arbiter: RTL and testbench

- Shares the single memory refill port between two cache requesters: port 0 is the ICache, port 1 is the DCache.
- Round-robin arbitration on the request channel. A small in-order ID FIFO tracks outstanding requests so that response beats and nacks are steered back to their owner.
- Sits between the cache refill interfaces and the memory controller. Memory responses return in request order.

---
 rtl/mem_refill_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_refill_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// Two-port (ICache=0, DCache=1) refill arbiter with an in-order owner-ID FIFO for response steering.
// Optional MEM_ARB_DCACHE_PRIORITY_EN: port 1 wins ties instead of round-robin.
module mem_refill_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int MEM_DATA_BITS   = 128,
  parameter int MEM_DATA_CYCLES = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [ADDR_BITS-1:0]     req0_addr,
  output logic                     resp0_val,
  output logic                     resp0_nack,
  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [ADDR_BITS-1:0]     req1_addr,
  output logic                     resp1_val,
  output logic                     resp1_nack,
  output logic [MEM_DATA_BITS-1:0] resp_data,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  input  logic                     mem_resp_val,
  input  logic                     mem_resp_nack,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
  output logic                     orphan_err
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(MEM_DATA_CYCLES);

  logic                       lock_q, lock_d, lock_id_q, lock_id_d, last_q, last_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wr_q, rd_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       full_q, full_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic                       orphan_q;
  logic                       grant, req_vld, accept, empty, head;
  logic                       beat_v, nack_v, last_beat, push, pop;

  always_comb begin
    grant = req1_val;
    if (lock_q)                    grant = lock_id_q;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    else if (req0_val && req1_val) grant = 1'b1;
`else
    else if (req0_val && req1_val) grant = ~last_q;
`endif
  end

  assign req_vld      = grant ? req1_val : req0_val;
  assign mem_req_val  = !reset && req_vld && !full_q;
  assign mem_req_addr = grant ? req1_addr : req0_addr;
  assign accept       = mem_req_val && mem_req_rdy;
  assign req0_rdy     = accept && !grant;
  assign req1_rdy     = accept && grant;

  // Response side: steer by FIFO head; val beats take precedence over a same-cycle nack.
  assign empty      = (cnt_q == '0);
  assign head       = fifo_q[rd_q];
  assign beat_v     = !reset && mem_resp_val && !empty;
  assign nack_v     = !reset && mem_resp_nack && !mem_resp_val && !empty && (beat_q == '0);
  assign last_beat  = beat_v && (beat_q == BW'(MEM_DATA_CYCLES - 1));
  assign push       = accept;
  assign pop        = last_beat || nack_v;
  assign resp0_val  = beat_v && !head;
  assign resp1_val  = beat_v && head;
  assign resp0_nack = nack_v && !head;
  assign resp1_nack = nack_v && head;
  assign resp_data  = mem_resp_data;
  assign orphan_err = orphan_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    if (accept) begin
      lock_d = 1'b0;
      last_d = grant;
    end else if (mem_req_val && !mem_req_rdy) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end else if (lock_q && !(lock_id_q ? req1_val : req0_val)) begin
      lock_d = 1'b0;
    end
    beat_d = beat_q;
    if (last_beat)   beat_d = '0;
    else if (beat_v) beat_d = beat_q + 1'b1;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    full_d = (cnt_d == CW'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      fifo_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      beat_q    <= '0;
      orphan_q  <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      beat_q    <= beat_d;
      if (push) begin
        fifo_q[wr_q] <= grant;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if ((mem_resp_val || mem_resp_nack) && empty) orphan_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && mem_resp_val && mem_resp_nack)
      $warning("mem_refill_arbiter: resp val and nack together, nack ignored");
`endif
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomized + directed bench against a queue-based reference model of the refill arbiter.
module tb_mem_refill_arbiter;
  localparam int AB = 28, DB = 128, NB = 4, MO = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic          req0_val = 0, req1_val = 0, mem_req_rdy = 0, mem_resp_val = 0, mem_resp_nack = 0;
  logic [AB-1:0] req0_addr = '0, req1_addr = '0;
  logic [DB-1:0] mem_resp_data = '0;
  logic          req0_rdy, req1_rdy, resp0_val, resp1_val, resp0_nack, resp1_nack;
  logic          mem_req_val, orphan_err;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] resp_data;

  mem_refill_arbiter #(.ADDR_BITS(AB), .MEM_DATA_BITS(DB), .MEM_DATA_CYCLES(NB),
                       .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr),
    .resp0_val(resp0_val), .resp0_nack(resp0_nack),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr),
    .resp1_val(resp1_val), .resp1_nack(resp1_nack),
    .resp_data(resp_data), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack),
    .mem_resp_data(mem_resp_data), .orphan_err(orphan_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  // Reference model: owner queue, beat counter, round-robin memory, lock.
  int q[$];
  int beats, last, lk_id;
  bit lk, orph, prio;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); beats = 0; last = 1; lk = 0; lk_id = 0; orph = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; req0_val = 1; req1_val = 1; mem_req_rdy = 1; mem_resp_val = 1; mem_resp_nack = 0;
    #2;
    chk("rst_mreq", mem_req_val, 0);
    chk("rst_rdy", {req0_rdy, req1_rdy}, 0);
    chk("rst_resp", {resp0_val, resp1_val, resp0_nack, resp1_nack}, 0);
    chk("rst_orphan", orphan_err, 0);
    @(negedge clk);
    reset = 0; req0_val = 0; req1_val = 0; mem_req_rdy = 0; mem_resp_val = 0;
    model_reset();
  endtask

  // Called at a negedge; drives, checks, then advances the model over the posedge.
  task automatic step(input bit v0, input logic [AB-1:0] a0, input bit v1, input logic [AB-1:0] a1,
                      input bit rrdy, input bit rv, input bit rn);
    logic [DB-1:0] d;
    int g, head;
    bit full, mreq, acc, empty, bv, nk;
    d = {$urandom, $urandom, $urandom, $urandom};
    req0_val = v0; req0_addr = a0; req1_val = v1; req1_addr = a1;
    mem_req_rdy = rrdy; mem_resp_val = rv; mem_resp_nack = rn; mem_resp_data = d;
    #2;
    if (lk)            g = lk_id;
    else if (v0 && v1) g = prio ? 1 : 1 - last;
    else               g = v1 ? 1 : 0;
    full  = (q.size() >= MO);
    mreq  = (g == 1 ? v1 : v0) && !full;
    acc   = mreq && rrdy;
    empty = (q.size() == 0);
    head  = empty ? 0 : q[0];
    bv    = rv && !empty;
    nk    = rn && !rv && !empty && beats == 0;
    chk("mem_req_val", mem_req_val, mreq);
    if (mreq) chk("mem_req_addr", mem_req_addr, g == 1 ? a1 : a0);
    chk("req0_rdy", req0_rdy, acc && g == 0);
    chk("req1_rdy", req1_rdy, acc && g == 1);
    chk("resp0_val", resp0_val, bv && head == 0);
    chk("resp1_val", resp1_val, bv && head == 1);
    chk("resp0_nack", resp0_nack, nk && head == 0);
    chk("resp1_nack", resp1_nack, nk && head == 1);
    chk("resp_data", resp_data, d);
    chk("orphan_err", orphan_err, orph);
    @(posedge clk);
    if ((rv || rn) && empty) orph = 1;
    if (bv) begin
      beats++;
      if (beats == NB) begin beats = 0; void'(q.pop_front()); end
    end else if (nk) void'(q.pop_front());
    if (acc) begin q.push_back(g); last = g; lk = 0; end
    else if (mreq && !rrdy) begin lk = 1; lk_id = g; end
    else if (lk && !(lk_id == 1 ? v1 : v0)) lk = 0;
    @(negedge clk);
  endtask

  initial begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    prio = 1;
`else
    prio = 0;
`endif
    model_reset();
    // Single ICache refill, four beats back.
    do_reset();
    step(1, 28'h0000123, 0, 0, 1, 0, 0);
    repeat (NB) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("fifo_empty_model", q.size(), 0);
    // Both valid: alternation, fill to full, then drain one response.
    do_reset();
    repeat (6) step(1, 28'h0000aaa, 1, 28'h0000bbb, 1, 0, 0);
    repeat (NB) step(1, 28'h0000aaa, 1, 28'h0000bbb, 1, 1, 0);
    repeat (2) step(1, 28'h0000aaa, 1, 28'h0000bbb, 1, 0, 0);
    // Lock held under backpressure while port 0 joins.
    do_reset();
    step(0, 28'h1, 1, 28'h2222, 0, 0, 0);
    step(1, 28'h1, 1, 28'h2222, 0, 0, 0);
    step(1, 28'h1, 1, 28'h2222, 0, 0, 0);
    step(1, 28'h1, 1, 28'h2222, 1, 0, 0);
    // Nack to head (port 0), then four beats for port 1.
    do_reset();
    step(1, 28'h10, 0, 0, 1, 0, 0);
    step(0, 0, 1, 28'h20, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (NB) step(0, 0, 0, 0, 0, 1, 0);
    // Orphan response, sticky until reset.
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // Randomized phases.
    for (int ph = 0; ph < 6; ph++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        bit rv, rn;
        rv = (q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
        rn = !rv && ($urandom_range(0, 9) == 0);
        step($urandom_range(0, 3) != 0, AB'($urandom), $urandom_range(0, 3) != 0, AB'($urandom),
             $urandom_range(0, 2) != 0, rv, rn);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
